// File: rtl/mips_cpu_muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_cpu_muldiv_pkg : op/state encodings for the multi-cycle mul/div unit
// Optional MADD/MADDU under MIPS_CPU_MULDIV_ACC_EN.   Rev 1.0
// ---------------------------------------------------------------------------
package mips_cpu_muldiv_pkg;

`ifdef MIPS_CPU_MULDIV_ACC_EN
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MADD  = 3'd4,
    MADDU = 3'd5
  } op_t;
`else
  localparam int OP_W = 2;
  typedef enum logic [OP_W-1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } op_t;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_cpu_muldiv : one-bit-per-cycle MULT/MULTU/DIV/DIVU unit with HI/LO.
// MIPS_CPU_MULDIV_ACC_EN adds MADD/MADDU.   Rev 1.0
// ---------------------------------------------------------------------------
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
  logic               done_q, done_d;

  op_t                op_in;
  logic               in_signed, in_div, run_div, is_acc;
  logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix, prod_acc;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign op_in   = op_t'(op);
  assign in_div  = (op_in == DIV) || (op_in == DIVU);
  assign run_div = (op_q == DIV) || (op_q == DIVU);
`ifdef MIPS_CPU_MULDIV_ACC_EN
  assign in_signed = (op_in == MULT) || (op_in == DIV) || (op_in == MADD);
  assign is_acc    = (op_q == MADD) || (op_q == MADDU);
`else
  assign in_signed = (op_in == MULT) || (op_in == DIV);
  assign is_acc    = 1'b0;
`endif

  assign a_abs = abs_val(a, in_signed);
  assign b_abs = abs_val(b, in_signed);

  // Multiply: acc_lo holds the multiplier and shifts right as product bits arrive.
  // Divide: acc_lo holds the dividend, shifting left while quotient bits fill in.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign prod_acc = prod_fix + (is_acc ? {hi_q, lo_q} : '0);
  // A zero divisor naturally yields all-ones quotient and |a| remainder;
  // restoring the sign of a on the remainder gives back a itself.
  assign quo_fix  = (neg_q && !div0_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          op_d      = op_in;
          count_d   = '0;
          acc_hi_d  = '0;
          acc_lo_d  = in_div ? a_abs : b_abs;
          opnd_d    = in_div ? b_abs : a_abs;
          neg_d     = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = in_signed && a[WIDTH-1];
          div0_d    = (b == '0);
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      RUN: begin
        if (run_div) begin
          if (!div_diff[WIDTH]) begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (run_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_acc[2*WIDTH-1:WIDTH];
          lo_d = prod_acc[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= MULT;
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_cpu_muldiv : directed self-checking bench for mips_cpu_muldiv.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [OP_W-1:0] op = '0;
  logic [31:0]     a = '0;
  logic [31:0]     b = '0;
  logic            hi_we = 1'b0;
  logic            lo_we = 1'b0;
  logic [31:0]     wdata = '0;
  logic            busy, done;
  logic [31:0]     hi, lo;

  int tests = 0;
  int fails = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Waits at negedges for done; busy must stay high until then.
  task automatic wait_done(input int c0, output int cyc, output bit busy_ok);
    cyc = c0;
    busy_ok = 1'b1;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is high.
  task automatic do_op(input logic [OP_W-1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] h, output logic [31:0] l, output int cyc);
    bit bz;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, cyc, bz);
    h = hi;
    l = lo;
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    hi_we = hw; lo_we = lw; wdata = d;
    @(posedge clk);
    #1 hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    logic [31:0] h, l;
    int cyc;
    bit bz;
    start = 1'b1; op = MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, cyc, bz);
    tests++; if (cyc !== 33) begin fails++; $display("FAIL multu_latency got %0d want 33", cyc); end
    tests++; if (bz !== 1'b1) begin fails++; $display("FAIL multu_busy_held got %b want 1", bz); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
    tests++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse got %b want 0", done); end
    h = hi; l = lo;
  endtask

  task automatic test_arith();
    logic [31:0] h, l;
    int cyc;
    do_op(MULT, 32'hFFFF_FFFD, 32'd7, h, l, cyc);
    tests++; if (h !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", h); end
    tests++; if (l !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo got %h want ffffffeb", l); end
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, h, l, cyc);
    tests++; if (l !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_lo got %h want fffffffd", l); end
    tests++; if (h !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg_hi got %h want ffffffff", h); end
    tests++; if (cyc !== 33) begin fails++; $display("FAIL div_latency got %0d want 33", cyc); end
    do_op(DIV, 32'd7, 32'hFFFF_FFFE, h, l, cyc);
    tests++; if (l !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_negb_lo got %h want fffffffd", l); end
    tests++; if (h !== 32'h0000_0001) begin fails++; $display("FAIL div_negb_hi got %h want 00000001", h); end
    do_op(DIVU, 32'd7, 32'd2, h, l, cyc);
    tests++; if (l !== 32'd3) begin fails++; $display("FAIL divu_lo got %h want 3", l); end
    tests++; if (h !== 32'd1) begin fails++; $display("FAIL divu_hi got %h want 1", h); end
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l, cyc);
    tests++; if (l !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo got %h want 80000000", l); end
    tests++; if (h !== 32'h0) begin fails++; $display("FAIL div_ovf_hi got %h want 0", h); end
    do_op(DIVU, 32'h0000_1234, 32'h0, h, l, cyc);
    tests++; if (l !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu0_lo got %h want ffffffff", l); end
    tests++; if (h !== 32'h0000_1234) begin fails++; $display("FAIL divu0_hi got %h want 00001234", h); end
    tests++; if (cyc !== 33) begin fails++; $display("FAIL divu0_latency got %0d want 33", cyc); end
    do_op(DIV, 32'hFFFF_FFF9, 32'h0, h, l, cyc);
    tests++; if (l !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_lo got %h want ffffffff", l); end
    tests++; if (h !== 32'hFFFF_FFF9) begin fails++; $display("FAIL div0_hi got %h want fffffff9", h); end
    @(negedge clk);
  endtask

  task automatic test_hilo_write();
    write_hilo(1'b1, 1'b0, 32'hA5A5_A5A5);
    tests++; if (hi !== 32'hA5A5_A5A5) begin fails++; $display("FAIL mthi_hi got %h want a5a5a5a5", hi); end
    tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mthi_lo_kept got %h want ffffffff", lo); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mthi_done got %b want 0", done); end
    write_hilo(1'b1, 1'b1, 32'h1357_9BDF);
    tests++; if (hi !== 32'h1357_9BDF) begin fails++; $display("FAIL both_hi got %h want 13579bdf", hi); end
    tests++; if (lo !== 32'h1357_9BDF) begin fails++; $display("FAIL both_lo got %h want 13579bdf", lo); end
  endtask

  task automatic test_start_wins();
    int cyc;
    bit bz;
    start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 start = 1'b0; lo_we = 1'b0;
    tests++; if (lo !== 32'h1357_9BDF) begin fails++; $display("FAIL start_wins_lo_run got %h want 13579bdf", lo); end
    wait_done(0, cyc, bz);
    tests++; if (lo !== 32'd6) begin fails++; $display("FAIL start_wins_lo got %h want 6", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL start_wins_hi got %h want 0", hi); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    bit bz;
    write_hilo(1'b1, 1'b1, 32'h5A5A_0000);
    start = 1'b1; op = MULTU; a = 32'h10; b = 32'h10;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_0000;
    @(posedge clk);
    #1 hi_we = 1'b0; lo_we = 1'b0;
    tests++; if (hi !== 32'h5A5A_0000) begin fails++; $display("FAIL busy_mthi_hi got %h want 5a5a0000", hi); end
    tests++; if (lo !== 32'h5A5A_0000) begin fails++; $display("FAIL busy_mtlo_lo got %h want 5a5a0000", lo); end
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = DIV; a = 32'd100; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(6, cyc, bz);
    tests++; if (cyc !== 33) begin fails++; $display("FAIL ignore_latency got %0d want 33", cyc); end
    tests++; if (bz !== 1'b1) begin fails++; $display("FAIL ignore_busy_held got %b want 1", bz); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL ignore_hi got %h want 0", hi); end
    tests++; if (lo !== 32'h100) begin fails++; $display("FAIL ignore_lo got %h want 00000100", lo); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l;
    int cyc;
    do_op(DIVU, 32'd100, 32'd7, h, l, cyc);
    tests++; if (l !== 32'd14) begin fails++; $display("FAIL b2b_first_lo got %h want e", l); end
    tests++; if (h !== 32'd2) begin fails++; $display("FAIL b2b_first_hi got %h want 2", h); end
    do_op(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, cyc);
    tests++; if (cyc !== 33) begin fails++; $display("FAIL b2b_latency got %0d want 33", cyc); end
    tests++; if (l !== 32'd1) begin fails++; $display("FAIL b2b_second_lo got %h want 1", l); end
    tests++; if (h !== 32'd0) begin fails++; $display("FAIL b2b_second_hi got %h want 0", h); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
    start = 1'b1; op = MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL midrst_hi got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL midrst_lo got %h want 0", lo); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done got %b want 0", done); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (done !== 1'b0 || hi !== 32'h0) begin fails++; $display("FAIL midrst_no_result got done=%b hi=%h want 0/0", done, hi); end
  endtask

`ifdef MIPS_CPU_MULDIV_ACC_EN
  task automatic test_madd();
    logic [31:0] h, l;
    int cyc;
    write_hilo(1'b1, 1'b0, 32'h0);
    write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF);
    do_op(MADDU, 32'd1, 32'd1, h, l, cyc);
    tests++; if (h !== 32'd1) begin fails++; $display("FAIL maddu_hi got %h want 1", h); end
    tests++; if (l !== 32'd0) begin fails++; $display("FAIL maddu_lo got %h want 0", l); end
    tests++; if (cyc !== 33) begin fails++; $display("FAIL maddu_latency got %0d want 33", cyc); end
    do_op(MADD, 32'hFFFF_FFFF, 32'd1, h, l, cyc);
    tests++; if (h !== 32'd0) begin fails++; $display("FAIL madd_hi got %h want 0", h); end
    tests++; if (l !== 32'hFFFF_FFFF) begin fails++; $display("FAIL madd_lo got %h want ffffffff", l); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_multu();
    test_arith();
    test_hilo_write();
    test_start_wins();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MIPS_CPU_MULDIV_ACC_EN
    test_madd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
